// File: rtl/pattern_pkt_gen.sv
// Pattern packet generator: emits framed test packets with a marker pattern
// at a chosen payload position. It is configured and observed through a
// small register block on the register ring.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a rising edge of run
// MOD_HDR | module header word (ctrl 0xFF, port and length fields)
// HDR     | three header words carrying seq and index 1..3
// PAYLOAD | N payload words; the pattern replaces word P; the last has ctrl 0x01
// GAP     | G idle cycles between packets

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef PKT_GEN_REG_ADDR_WIDTH
`define PKT_GEN_REG_ADDR_WIDTH 4
`endif
`ifndef PKT_GEN_BLOCK_ADDR
`define PKT_GEN_BLOCK_ADDR 19'h00010
`endif

// Register-ring slave: counters first, then software regs, then hardware regs.
module generic_regs #(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int TAG               = 0,
  parameter int REG_ADDR_WIDTH    = 4,
  parameter int NUM_COUNTERS      = 0,
  parameter int NUM_SOFTWARE_REGS = 1,
  parameter int NUM_HARDWARE_REGS = 1
) (
  input  logic                                              reg_req_in,
  input  logic                                              reg_ack_in,
  input  logic                                              reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]                    reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]                   reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]                      reg_src_in,
  output logic                                              reg_req_out,
  output logic                                              reg_ack_out,
  output logic                                              reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]                    reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]                   reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]                      reg_src_out,
  output logic [NUM_SOFTWARE_REGS*`CPCI_NF2_DATA_WIDTH-1:0] software_regs,
  input  logic [NUM_HARDWARE_REGS*`CPCI_NF2_DATA_WIDTH-1:0] hardware_regs,
  input  logic                                              clk,
  input  logic                                              reset
);
  localparam int DW      = `CPCI_NF2_DATA_WIDTH;
  localparam int TAG_W   = `UDP_REG_ADDR_WIDTH - REG_ADDR_WIDTH;
  localparam int SW_BASE = NUM_COUNTERS;
  localparam int HW_BASE = NUM_COUNTERS + NUM_SOFTWARE_REGS;

  logic [DW-1:0]             sw_q [NUM_SOFTWARE_REGS];
  logic [DW-1:0]             rd_val;
  logic [REG_ADDR_WIDTH-1:0] idx;
  logic                      hit;

  assign idx = reg_addr_in[REG_ADDR_WIDTH-1:0];
  assign hit = reg_req_in && !reg_ack_in &&
               (reg_addr_in[`UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH] == TAG_W'(TAG));

  // Flatten the software register array onto the output bus
  always_comb begin
    software_regs = '0;
    for (int i = 0; i < NUM_SOFTWARE_REGS; i++) software_regs[i*DW +: DW] = sw_q[i];
  end

  // Read mux; unmapped offsets inside the block read as a marker value
  always_comb begin
    rd_val = DW'(32'hDEAD_BEEF);
    for (int i = 0; i < NUM_SOFTWARE_REGS; i++)
      if (int'(idx) == SW_BASE + i) rd_val = sw_q[i];
    for (int i = 0; i < NUM_HARDWARE_REGS; i++)
      if (int'(idx) == HW_BASE + i) rd_val = hardware_regs[i*DW +: DW];
  end

  // Pass requests down the ring, claiming and serving those aimed at this block
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b1;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
      for (int i = 0; i < NUM_SOFTWARE_REGS; i++) sw_q[i] <= '0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_ack_out     <= reg_ack_in | hit;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_src_out     <= reg_src_in;
      reg_data_out    <= (hit && reg_rd_wr_L_in) ? rd_val : reg_data_in;
      for (int i = 0; i < NUM_SOFTWARE_REGS; i++)
        if (hit && !reg_rd_wr_L_in && int'(idx) == SW_BASE + i) sw_q[i] <= reg_data_in;
    end
  end
endmodule

module pattern_pkt_gen #(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = DATA_WIDTH/8,
  parameter int UDP_REG_SRC_WIDTH = 2
) (
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  input  logic                             reg_req_in,
  input  logic                             reg_ack_in,
  input  logic                             reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_in,
  output logic                             reg_req_out,
  output logic                             reg_ack_out,
  output logic                             reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_out,
  input  logic                             clk,
  input  logic                             reset
);
  typedef enum logic [2:0] {IDLE, MOD_HDR, HDR, PAYLOAD, GAP} state_t;

  state_t       state, state_n;
  logic [127:0] software_regs;
  logic [31:0]  pattern_high, pattern_low, gen_cfg, gen_cmd, status, pkts_sent, seq;
  logic [15:0]  remaining, gap_cnt, g_lat, word_len;
  logic [7:0]   n_lat, p_lat, word_idx, ctrl8;
  logic [55:0]  pat_lat;
  logic [63:0]  word64;
  logic [1:0]   hdr_idx;
  logic         unlimited, run_d, run, run_rise, start_cmd, load_cfg, last_word;
  logic         unused_bits;

  assign pattern_high = software_regs[31:0];
  assign pattern_low  = software_regs[63:32];
  assign gen_cfg      = software_regs[95:64];
  assign gen_cmd      = software_regs[127:96];
  assign unused_bits  = ^{pattern_high[31:24], gen_cmd[15:2]};

  assign run       = gen_cmd[0];
  assign run_rise  = run & ~run_d;
  assign start_cmd = (state == IDLE) && run_rise;
  assign status    = {remaining, 15'h0, state != IDLE};
  assign out_wr    = ((state == MOD_HDR) || (state == HDR) || (state == PAYLOAD)) && out_rdy;
  assign last_word = (state == PAYLOAD) && (word_idx == n_lat - 8'd1);
  assign word_len  = 16'd3 + {8'h0, n_lat};

  generic_regs #(
    .UDP_REG_SRC_WIDTH (UDP_REG_SRC_WIDTH),
    .TAG               (`PKT_GEN_BLOCK_ADDR),
    .REG_ADDR_WIDTH    (`PKT_GEN_REG_ADDR_WIDTH),
    .NUM_COUNTERS      (0),
    .NUM_SOFTWARE_REGS (4),
    .NUM_HARDWARE_REGS (2)
  ) u_regs (
    .reg_req_in      (reg_req_in),
    .reg_ack_in      (reg_ack_in),
    .reg_rd_wr_L_in  (reg_rd_wr_L_in),
    .reg_addr_in     (reg_addr_in),
    .reg_data_in     (reg_data_in),
    .reg_src_in      (reg_src_in),
    .reg_req_out     (reg_req_out),
    .reg_ack_out     (reg_ack_out),
    .reg_rd_wr_L_out (reg_rd_wr_L_out),
    .reg_addr_out    (reg_addr_out),
    .reg_data_out    (reg_data_out),
    .reg_src_out     (reg_src_out),
    .software_regs   (software_regs),
    .hardware_regs   ({status, pkts_sent}),
    .clk             (clk),
    .reset           (reset)
  );

  // Next state; config is re-latched at every packet start, run is only
  // sampled at packet boundaries so a packet is never cut short
  always_comb begin
    state_n  = state;
    load_cfg = 1'b0;
    case (state)
      IDLE:    if (run_rise) begin state_n = MOD_HDR; load_cfg = 1'b1; end
      MOD_HDR: if (out_wr) state_n = HDR;
      HDR:     if (out_wr && hdr_idx == 2'd3) state_n = PAYLOAD;
      PAYLOAD: if (out_wr && last_word) begin
                 if (g_lat != 16'd0) state_n = GAP;
                 else if (run && (unlimited || remaining > 16'd1)) begin
                   state_n = MOD_HDR; load_cfg = 1'b1;
                 end else state_n = IDLE;
               end
      GAP:     if (gap_cnt == 16'd1) begin
                 if (run && (unlimited || remaining != 16'd0)) begin
                   state_n = MOD_HDR; load_cfg = 1'b1;
                 end else state_n = IDLE;
               end
      default: state_n = IDLE;
    endcase
  end

  // Word formatting; outputs depend only on state, so they hold during stalls
  always_comb begin
    word64 = '0;
    ctrl8  = 8'h00;
    case (state)
      MOD_HDR: begin
        ctrl8  = 8'hFF;
        word64 = {16'h0001, word_len, 16'h0000, word_len[12:0], 3'b000};
      end
      HDR:     word64 = {seq, 30'h0, hdr_idx};
      PAYLOAD: begin
        ctrl8  = last_word ? 8'h01 : 8'h00;
        word64 = (word_idx == p_lat) ? {pat_lat, 8'h00} : {seq, 24'h0, word_idx};
      end
      default: ;
    endcase
    out_data = DATA_WIDTH'(word64);
    out_ctrl = CTRL_WIDTH'(ctrl8);
  end

  // State, counters and latched packet configuration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      run_d     <= 1'b0;
      seq       <= '0;
      pkts_sent <= '0;
      remaining <= '0;
      unlimited <= 1'b0;
      gap_cnt   <= '0;
      hdr_idx   <= 2'd1;
      word_idx  <= '0;
      n_lat     <= 8'd1;
      p_lat     <= '0;
      g_lat     <= '0;
      pat_lat   <= '0;
    end else begin
      state <= state_n;
      run_d <= run;
      if (start_cmd) begin
        remaining <= gen_cmd[31:16];
        unlimited <= (gen_cmd[31:16] == 16'd0);
      end
      if (out_wr && state == HDR) hdr_idx <= hdr_idx + 2'd1;
      if (out_wr && state == PAYLOAD) word_idx <= word_idx + 8'd1;
      if (state == GAP) gap_cnt <= gap_cnt - 16'd1;
      if (out_wr && last_word) begin
        seq     <= seq + 32'd1;
        gap_cnt <= g_lat;
        if (!unlimited) remaining <= remaining - 16'd1;
      end
      if (gen_cmd[1]) pkts_sent <= '0;
      else if (out_wr && last_word) pkts_sent <= pkts_sent + 32'd1;
      if (load_cfg) begin
        n_lat    <= (gen_cfg[7:0] == 8'd0) ? 8'd1 : gen_cfg[7:0];
        p_lat    <= gen_cfg[15:8];
        g_lat    <= gen_cfg[31:16];
        pat_lat  <= {pattern_high[23:0], pattern_low};
        hdr_idx  <= 2'd1;
        word_idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pattern_pkt_gen.sv
// Directed bench for pattern_pkt_gen with a word scoreboard.

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef PKT_GEN_REG_ADDR_WIDTH
`define PKT_GEN_REG_ADDR_WIDTH 4
`endif
`ifndef PKT_GEN_BLOCK_ADDR
`define PKT_GEN_BLOCK_ADDR 19'h00010
`endif

module tb_pattern_pkt_gen;
  localparam int RAW   = `PKT_GEN_REG_ADDR_WIDTH;
  localparam int TAG_W = `UDP_REG_ADDR_WIDTH - RAW;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr, out_rdy;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in, reg_addr_out;
  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in, reg_data_out;
  logic [1:0]  reg_src_in, reg_src_out;
  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;

  typedef struct packed {logic [7:0] ctrl; logic [63:0] data;} word_t;
  word_t exp_q[$];
  int    gaps[$];
  int    tests_run = 0, tests_failed = 0;
  int    cyc = 0, eop_cyc = 0;
  bit    have_eop = 0, toggle_rdy = 0, prev_pend = 0;
  logic [63:0] prev_data;
  logic [31:0] rd;

  always #5 clk = ~clk;

  pattern_pkt_gen dut (
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .clk(clk), .reset(reset)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected packet words, optionally truncated to the first max_words
  task automatic push_pkt(input logic [31:0] seq, input logic [7:0] n_raw, input logic [7:0] p,
                          input logic [55:0] pat, input int max_words);
    word_t w[$];
    int n = (n_raw == 0) ? 1 : int'(n_raw);
    logic [15:0] wl = 16'(3 + n);
    w.push_back({8'hFF, 16'h0001, wl, 16'h0000, 16'(wl * 8)});
    for (int i = 1; i <= 3; i++) w.push_back({8'h00, seq, 32'(i)});
    for (int i = 0; i < n; i++)
      w.push_back({(i == n - 1) ? 8'h01 : 8'h00,
                   (i == int'(p)) ? {pat, 8'h00} : {seq, 32'(i)}});
    for (int i = 0; i < w.size() && i < max_words; i++) exp_q.push_back(w[i]);
  endtask

  task automatic reg_access(input bit wr, input int idx, input logic [31:0] wdata,
                            output logic [31:0] rdata);
    @(posedge clk); #1;
    reg_req_in = 1'b1; reg_rd_wr_L_in = !wr; reg_data_in = wdata;
    reg_addr_in = {TAG_W'(`PKT_GEN_BLOCK_ADDR), RAW'(idx)};
    @(posedge clk); #1;
    reg_req_in = 1'b0; reg_rd_wr_L_in = 1'b1; reg_data_in = '0;
    check("reg_ack", 64'(reg_ack_out), 64'd1);
    rdata = reg_data_out;
  endtask

  task automatic reg_wr(input int idx, input logic [31:0] d);
    logic [31:0] dummy;
    reg_access(1'b1, idx, d, dummy);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 600 && exp_q.size() > 0; i++) @(posedge clk);
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_idle(output logic [31:0] st);
    for (int i = 0; i < 40; i++) begin
      reg_access(1'b0, 5, 32'h0, st);
      if (!st[0]) break;
    end
  endtask

  // Scoreboard pop, stall and gap monitoring on the falling edge
  always @(negedge clk) begin
    word_t w;
    cyc++;
    if (prev_pend) check("stall_hold", out_data, prev_data);
    if (out_wr) begin
      check("wr_needs_rdy", 64'(out_rdy), 64'd1);
      if (exp_q.size() == 0) check("extra_word", 64'(exp_q.size()), 64'd1);
      else begin
        w = exp_q.pop_front();
        check("word_ctrl", 64'(out_ctrl), 64'(w.ctrl));
        check("word_data", out_data, w.data);
      end
      if (out_ctrl == 8'hFF && have_eop) gaps.push_back(cyc - eop_cyc - 1);
      if (out_ctrl == 8'h01) begin eop_cyc = cyc; have_eop = 1; end
    end
    prev_pend = !out_rdy && !reset && exp_q.size() > 0 &&
                out_ctrl === exp_q[0].ctrl && out_data === exp_q[0].data;
    prev_data = out_data;
  end

  // Downstream ready: constant or toggling every cycle
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_rdy = toggle_rdy ? ~out_rdy : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    reg_req_in = 0; reg_ack_in = 0; reg_rd_wr_L_in = 1; reg_addr_in = '0;
    reg_data_in = '0; reg_src_in = '0;
    repeat (3) @(negedge clk);
    check("rst_out_wr", 64'(out_wr), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    reg_access(1'b0, 4, 32'h0, rd); check("rst_pkts_sent", 64'(rd), 64'd0);
    reg_access(1'b0, 5, 32'h0, rd); check("rst_status", 64'(rd), 64'd0);

    // single packet N=2 P=1 C=1 G=0
    reg_wr(0, 32'h0011_2233);
    reg_wr(1, 32'h4455_6677);
    reg_wr(2, 32'h0000_0102);
    push_pkt(32'd0, 8'd2, 8'd1, 56'h11223344556677, 99);
    reg_wr(3, 32'h0001_0001);
    wait_drain("t1_drain");
    wait_idle(rd); check("t1_status", 64'(rd), 64'd0);
    reg_access(1'b0, 4, 32'h0, rd); check("t1_pkts_sent", 64'(rd), 64'd1);

    // same packet with ready toggling every cycle
    reg_wr(3, 32'h0);
    toggle_rdy = 1;
    push_pkt(32'd1, 8'd2, 8'd1, 56'h11223344556677, 99);
    reg_wr(3, 32'h0001_0001);
    wait_drain("t2_drain");
    toggle_rdy = 0;
    wait_idle(rd); check("t2_status", 64'(rd), 64'd0);
    reg_access(1'b0, 4, 32'h0, rd); check("t2_pkts_sent", 64'(rd), 64'd2);

    // three packets C=3 G=4, N=3 P=0
    reg_wr(3, 32'h0000_0002);
    reg_access(1'b0, 4, 32'h0, rd); check("t3_cleared", 64'(rd), 64'd0);
    reg_wr(2, 32'h0004_0003);
    for (int s = 2; s <= 4; s++) push_pkt(32'(s), 8'd3, 8'd0, 56'h11223344556677, 99);
    have_eop = 0; gaps.delete();
    reg_wr(3, 32'h0003_0001);
    reg_access(1'b0, 5, 32'h0, rd); check("t3_status_start", 64'(rd), 64'h0003_0001);
    wait_drain("t3_drain");
    wait_idle(rd); check("t3_status_end", 64'(rd), 64'd0);
    reg_access(1'b0, 4, 32'h0, rd); check("t3_pkts_sent", 64'(rd), 64'd3);
    check("t3_gap_count", 64'(gaps.size()), 64'd2);
    if (gaps.size() == 2) begin
      check("t3_gap0", 64'(gaps[0]), 64'd4);
      check("t3_gap1", 64'(gaps[1]), 64'd4);
    end

    // unlimited, run cleared during second packet's header
    reg_wr(3, 32'h0000_0002);
    reg_wr(2, 32'h0000_0102);
    push_pkt(32'd5, 8'd2, 8'd1, 56'h11223344556677, 99);
    push_pkt(32'd6, 8'd2, 8'd1, 56'h11223344556677, 99);
    reg_wr(3, 32'h0000_0001);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (exp_q.size() <= 5) break;
    end
    check("t4_in_hdr", 64'(exp_q.size()), 64'd5);
    reg_wr(3, 32'h0);
    wait_drain("t4_drain");
    repeat (20) @(posedge clk);
    wait_idle(rd); check("t4_status", 64'(rd), 64'd0);
    reg_access(1'b0, 4, 32'h0, rd); check("t4_pkts_sent", 64'(rd), 64'd2);

    // N=0 P=5, then reset during the next packet's payload
    reg_wr(2, 32'h0000_0500);
    push_pkt(32'd7, 8'd0, 8'd5, 56'h11223344556677, 99);
    push_pkt(32'd8, 8'd0, 8'd5, 56'h11223344556677, 4);
    reg_wr(3, 32'h0002_0001);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    #1;
    check("t5_pre_rst_ctrl", 64'(out_ctrl), 64'h01);
    reset = 1'b1;
    #1;
    check("t5_rst_out_wr", 64'(out_wr), 64'd0);
    check("t5_rst_out_data", out_data, 64'd0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    reg_access(1'b0, 4, 32'h0, rd); check("t5_pkts_sent", 64'(rd), 64'd0);
    reg_access(1'b0, 5, 32'h0, rd); check("t5_status", 64'(rd), 64'd0);
    repeat (20) @(posedge clk);

    // resume after reset: registers back at zero, seq restarts
    push_pkt(32'd0, 8'd0, 8'd0, 56'h0, 99);
    reg_wr(3, 32'h0001_0001);
    wait_drain("t6_drain");
    wait_idle(rd); check("t6_status", 64'(rd), 64'd0);
    reg_access(1'b0, 4, 32'h0, rd); check("t6_pkts_sent", 64'(rd), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
